// File: rtl/proc_phase_sequencer.sv
// proc_phase_sequencer: steps the processor through its five instruction phases, with stall/start/halt control and cycle/instruction counters.
module proc_phase_sequencer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STALL,
  input  logic                 HALT_REQ,
  output logic [2:0]           STATE,
  output logic [4:0]           PHASE,
  output logic                 INSTR_DONE,
  output logic                 HALT_ACK,
  output logic [CNT_WIDTH-1:0] CYCLE_COUNT,
  output logic [CNT_WIDTH-1:0] INSTR_COUNT
);
  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXE    = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    HALTED = 3'b110,
    IDLE   = 3'b111
  } state_t;
  state_t               state_q, state_d;
  logic [4:0]           phase_q, phase_d;
  logic                 done_q, done_d;
  logic                 ack_q, ack_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] ins_q, ins_d;
  logic                 active, wb_exit;
  always_comb begin
    state_d = state_q;
    active  = state_q inside {FETCH, DECODE, EXE, MEM, WB};
    wb_exit = (state_q == WB) && !STALL;
    case (state_q)
      IDLE:    state_d = HALT_REQ ? HALTED : START ? FETCH : IDLE;
      FETCH:   state_d = STALL ? FETCH : DECODE;
      DECODE:  state_d = STALL ? DECODE : EXE;
      EXE:     state_d = STALL ? EXE : MEM;
      MEM:     state_d = STALL ? MEM : WB;
      WB:      state_d = STALL ? WB : (pend_q || HALT_REQ) ? HALTED : FETCH;
      HALTED:  state_d = HALT_REQ ? HALTED : IDLE;
      default: state_d = IDLE;
    endcase
    // phase strobes decode the next state so they change in the same edge as STATE
    phase_d = (state_d inside {FETCH, DECODE, EXE, MEM, WB}) ? (5'b00001 << state_d) : 5'b00000;
    ack_d   = state_d == HALTED;
    done_d  = wb_exit;
    pend_d  = (state_d == HALTED) ? 1'b0 : (active && HALT_REQ) ? 1'b1 : pend_q;
    cyc_d   = active ? cyc_q + CNT_WIDTH'(1) : cyc_q;
    ins_d   = wb_exit ? ins_q + CNT_WIDTH'(1) : ins_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end
  assign STATE       = state_q;
  assign PHASE       = phase_q;
  assign INSTR_DONE  = done_q;
  assign HALT_ACK    = ack_q;
  assign CYCLE_COUNT = cyc_q;
  assign INSTR_COUNT = ins_q;
endmodule

// File: tb/tb_proc_phase_sequencer.sv
// tb_proc_phase_sequencer: directed checks of phase stepping, stall, halt, wrap and async reset.
module tb_proc_phase_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic [2:0]  state, state_w;
  logic [4:0]  phase, phase_w;
  logic        done, done_w, ack, ack_w;
  logic [31:0] cyc, ins;
  logic [3:0]  cyc_w, ins_w;
  int          n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  proc_phase_sequencer u_dut (
    .CLK(clk), .RST(rst_n), .START(start), .STALL(stall), .HALT_REQ(halt_req),
    .STATE(state), .PHASE(phase), .INSTR_DONE(done), .HALT_ACK(ack),
    .CYCLE_COUNT(cyc), .INSTR_COUNT(ins)
  );
  proc_phase_sequencer #(.CNT_WIDTH(4)) u_w4 (
    .CLK(clk), .RST(rst_n), .START(start), .STALL(stall), .HALT_REQ(halt_req),
    .STATE(state_w), .PHASE(phase_w), .INSTR_DONE(done_w), .HALT_ACK(ack_w),
    .CYCLE_COUNT(cyc_w), .INSTR_COUNT(ins_w)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    #1;
    chk("rst_state", {29'd0, state}, 32'h7);
    chk("rst_phase", {27'd0, phase}, 32'h0);
    chk("rst_cnt", cyc | ins, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    // three back-to-back instructions; the 4-bit instance checks counter wrap
    do_reset();
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) step(1);
      chk($sformatf("phase_e%0d", k), {27'd0, phase}, 32'd1 << ((k - 1) % 5));
      chk($sformatf("done_e%0d", k), {31'd0, done}, (k == 6 || k == 11) ? 32'd1 : 32'd0);
    end
    step(1);
    chk("done_e16", {31'd0, done}, 32'd1);
    chk("cyc_e16", cyc, 32'd15);
    chk("ins_e16", ins, 32'd3);
    chk("w4_cyc_e16", {28'd0, cyc_w}, 32'd15);
    step(1);
    chk("w4_cyc_wrap", {28'd0, cyc_w}, 32'd0);
    step(4);
    chk("w4_cyc_e21", {28'd0, cyc_w}, 32'd4);
    chk("w4_ins_e21", {28'd0, ins_w}, 32'd4);
    chk("cyc_e21", cyc, 32'd20);
    chk("ins_e21", ins, 32'd4);
    // stall for 4 cycles in EXE
    do_reset();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    chk("stall_exe0", {29'd0, state}, 32'h2);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("stall_hold", {29'd0, state}, 32'h2);
    end
    stall = 1'b0;
    step(1);
    chk("stall_mem", {29'd0, state}, 32'h3);
    step(2);
    chk("stall_fetch", {29'd0, state}, 32'h0);
    chk("stall_cyc", cyc, 32'd9);
    chk("stall_ins", ins, 32'd1);
    chk("stall_done", {31'd0, done}, 32'd1);
    // one-cycle halt request during DECODE
    do_reset();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    halt_req = 1'b1;
    step(1);
    halt_req = 1'b0;
    step(2);
    chk("halt_wb", {29'd0, state}, 32'h4);
    chk("halt_ack_wb", {31'd0, ack}, 32'd0);
    step(1);
    chk("halt_state", {29'd0, state}, 32'h6);
    chk("halt_ack", {31'd0, ack}, 32'd1);
    chk("halt_phase", {27'd0, phase}, 32'h0);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_ins", ins, 32'd1);
    chk("halt_cyc", cyc, 32'd5);
    step(1);
    chk("halt_idle", {29'd0, state}, 32'h7);
    chk("halt_ack_off", {31'd0, ack}, 32'd0);
    chk("halt_cyc_hold", cyc, 32'd5);
    chk("halt_ins_hold", ins, 32'd1);
    // START and HALT_REQ together in IDLE, then START held through an instruction
    do_reset();
    start = 1'b1;
    halt_req = 1'b1;
    step(1);
    chk("both_state", {29'd0, state}, 32'h6);
    chk("both_cyc", cyc, 32'd0);
    step(1);
    chk("both_stay", {29'd0, state}, 32'h6);
    halt_req = 1'b0;
    step(1);
    chk("both_idle", {29'd0, state}, 32'h7);
    step(1);
    chk("start_fetch", {29'd0, state}, 32'h0);
    step(2);
    chk("start_ignored", {29'd0, state}, 32'h2);
    step(3);
    chk("start_next", {29'd0, state}, 32'h0);
    chk("start_ins", ins, 32'd1);
    start = 1'b0;
    // asynchronous reset while in MEM with a pending halt
    do_reset();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    halt_req = 1'b1;
    step(1);
    halt_req = 1'b0;
    step(1);
    chk("ar_mem", {29'd0, state}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_state", {29'd0, state}, 32'h7);
    chk("ar_phase", {27'd0, phase}, 32'h0);
    chk("ar_flags", {30'd0, done, ack}, 32'h0);
    chk("ar_cyc", cyc, 32'd0);
    chk("ar_ins", ins, 32'd0);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("ar_fetch", {29'd0, state}, 32'h0);
    step(5);
    chk("ar_no_halt", {29'd0, state}, 32'h0);
    chk("ar_ins1", ins, 32'd1);
    chk("ar_ack", {31'd0, ack}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
